// File: rtl/isa_types_pkg.sv
// Shared ISA-level types: data width, memory access width encoding and helpers.
package isa_types;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2
  } write_width_t;

  function automatic logic [2:0] width_bytes(write_width_t w);
    case (w)
      W_BYTE:  return 3'd1;
      W_HALF:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Byte-lane positioning for stores and shift/extend for loads across a two-word window.
module mem_lane_align
  import isa_types::*;
#(
  parameter int XLEN = isa_types::XLEN
) (
  input  logic [1:0]          off_i,
  input  write_width_t        width_i,
  input  logic                unsigned_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [XLEN-1:0]     lo_i,
  input  logic [XLEN-1:0]     hi_i,
  output logic [XLEN/4-1:0]   be8_o,
  output logic [2*XLEN-1:0]   d64_o,
  output logic [XLEN-1:0]     rdata_o
);

  localparam int NB2 = XLEN / 4;

  logic [2:0]      nbytes;
  logic [4:0]      sh;
  logic [NB2-1:0]  mask;
  logic [XLEN-1:0] shifted;

  assign nbytes  = width_bytes(width_i);
  assign sh      = {off_i, 3'b000};
  assign mask    = (NB2'(1) << nbytes) - NB2'(1);
  assign be8_o   = mask << off_i;
  assign d64_o   = {{XLEN{1'b0}}, wdata_i} << sh;
  assign shifted = XLEN'({hi_i, lo_i} >> sh);

  // Sign bit is masked by unsigned_i so LBU/LHU fall out of the same path.
  always_comb begin
    case (width_i)
      W_BYTE:  rdata_o = {{(XLEN-8){~unsigned_i & shifted[7]}}, shifted[7:0]};
      W_HALF:  rdata_o = {{(XLEN-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one request at a time, split into up to two SRAM word
// beats when the access straddles a word boundary, response held until taken.
module data_mem_responder
  import isa_types::*;
#(
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int XLEN           = isa_types::XLEN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  write_width_t              req_width,
  input  logic                      req_unsigned,
  input  logic [XLEN-1:0]           req_addr,
  input  logic [XLEN-1:0]           req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [XLEN-1:0]           resp_rdata,
  output logic                      sram_en,
  output logic                      sram_we,
  output logic [MEM_WORDS_LOG2-1:0] sram_addr,
  output logic [XLEN/8-1:0]         sram_be,
  output logic [XLEN-1:0]           sram_wdata,
  input  logic [XLEN-1:0]           sram_rdata
);

  localparam int NB = XLEN / 8;

  typedef enum logic [2:0] {IDLE, BEAT1, BEAT2, CAPTURE, RESP} state_t;

  state_t                    state_q;
  logic                      req_ready_q;
  logic [1:0]                off_q;
  write_width_t              width_q;
  logic                      write_q;
  logic                      uns_q;
  logic [XLEN-1:0]           wdata_q;
  logic                      split_q;
  logic [XLEN-1:0]           beat1_q;
  logic                      resp_valid_q;
  logic [XLEN-1:0]           resp_rdata_q;
  logic                      sram_en_q;
  logic                      sram_we_q;
  logic [MEM_WORDS_LOG2-1:0] sram_addr_q;
  logic [NB-1:0]             sram_be_q;
  logic [XLEN-1:0]           sram_wdata_q;

  // Aligner sees the live request while idle (to launch beat 1 at accept) and
  // the registered request afterwards (beat 2 lanes, load extension).
  logic                sel_req;
  logic [1:0]          al_off;
  write_width_t        al_width;
  logic                al_uns;
  logic [XLEN-1:0]     al_wdata;
  logic [XLEN-1:0]     al_lo;
  logic [XLEN-1:0]     al_hi;
  logic [2*NB-1:0]     be8;
  logic [2*XLEN-1:0]   d64;
  logic [XLEN-1:0]     ld_data;

  assign sel_req  = (state_q == IDLE);
  assign al_off   = sel_req ? req_addr[1:0] : off_q;
  assign al_width = sel_req ? req_width     : width_q;
  assign al_uns   = sel_req ? req_unsigned  : uns_q;
  assign al_wdata = sel_req ? req_wdata     : wdata_q;
  assign al_lo    = split_q ? beat1_q       : sram_rdata;
  assign al_hi    = split_q ? sram_rdata    : '0;

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .off_i      (al_off),
    .width_i    (al_width),
    .unsigned_i (al_uns),
    .wdata_i    (al_wdata),
    .lo_i       (al_lo),
    .hi_i       (al_hi),
    .be8_o      (be8),
    .d64_o      (d64),
    .rdata_o    (ld_data)
  );

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[XLEN-1:MEM_WORDS_LOG2+2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      off_q        <= '0;
      width_q      <= W_BYTE;
      write_q      <= 1'b0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      split_q      <= 1'b0;
      beat1_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_be_q    <= '0;
      sram_wdata_q <= '0;
    end else begin
      // SRAM is quiet unless a beat is launched below.
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_be_q    <= '0;
      sram_wdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (req_ready_q && req_valid) begin
            off_q        <= req_addr[1:0];
            width_q      <= req_width;
            write_q      <= req_write;
            uns_q        <= req_unsigned;
            wdata_q      <= req_wdata;
            split_q      <= |be8[2*NB-1:NB];
            req_ready_q  <= 1'b0;
            sram_en_q    <= 1'b1;
            sram_we_q    <= req_write;
            sram_addr_q  <= req_addr[MEM_WORDS_LOG2+1:2];
            sram_be_q    <= be8[NB-1:0];
            sram_wdata_q <= req_write ? d64[XLEN-1:0] : '0;
            state_q      <= BEAT1;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        BEAT1: begin
          if (split_q) begin
            sram_en_q    <= 1'b1;
            sram_we_q    <= write_q;
            sram_addr_q  <= sram_addr_q + 1'b1;
            sram_be_q    <= be8[2*NB-1:NB];
            sram_wdata_q <= write_q ? d64[2*XLEN-1:XLEN] : '0;
            state_q      <= BEAT2;
          end else if (!write_q) begin
            state_q <= CAPTURE;
          end else begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            state_q      <= RESP;
          end
        end
        BEAT2: begin
          beat1_q <= sram_rdata;
          if (!write_q) begin
            state_q <= CAPTURE;
          end else begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            state_q      <= RESP;
          end
        end
        CAPTURE: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= ld_data;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_be    = sram_be_q;
  assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: byte-level memory model predicts beats, lanes, latency and load data.
module tb_data_mem_responder;
  import isa_types::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_write, req_unsigned;
  write_width_t req_width;
  logic [31:0]  req_addr, req_wdata;
  logic         resp_valid, resp_ready;
  logic [31:0]  resp_rdata;
  logic         sram_en, sram_we;
  logic [9:0]   sram_addr;
  logic [3:0]   sram_be;
  logic [31:0]  sram_wdata;
  logic [31:0]  sram_rdata;

  always #5 clk = ~clk;

  data_mem_responder #(.MEM_WORDS_LOG2(10), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_width(req_width), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .sram_en(sram_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_be(sram_be), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  // Backing SRAM: byte-enabled writes, read data one cycle after the beat.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int l = 0; l < 4; l++)
          if (sram_be[l]) mem[sram_addr][8*l +: 8] <= sram_wdata[8*l +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs, filled in by the driver from the model.
  bit          chk_on = 0;
  int          e_k;
  logic        e_ready, e_rvalid, e_en, e_we;
  logic [9:0]  e_addr;
  logic [3:0]  e_be;
  logic [31:0] e_wdata, e_rdata;
  logic [9:0]  c1_addr, c2_addr;
  logic [3:0]  c1_be, c2_be;
  logic [31:0] c1_wd, c2_wd, c_rd;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("req_ready", req_ready, e_ready);
      chk("resp_valid", resp_valid, e_rvalid);
      chk("sram_en", sram_en, e_en);
      chk("sram_be", sram_be, e_be);
      chk("sram_wdata", sram_wdata, e_wdata);
      if (e_en) begin
        chk("sram_we", sram_we, e_we);
        chk("sram_addr", sram_addr, e_addr);
      end
      if (e_rvalid) begin
        chk("resp_rdata", resp_rdata, e_rdata);
        c_rd = resp_rdata;
      end
      if (e_k == 1) begin c1_addr = sram_addr; c1_be = sram_be; c1_wd = sram_wdata; end
      if (e_k == 2) begin c2_addr = sram_addr; c2_be = sram_be; c2_wd = sram_wdata; end
    end
  end

  task automatic idle_exp(input logic rdy);
    e_k = 0; e_ready = rdy; e_rvalid = 0; e_en = 0; e_we = 0;
    e_addr = 0; e_be = 0; e_wdata = 0; e_rdata = 0;
  endtask

  // Entered and left just after a rising edge, with the DUT idle and ready.
  task automatic run(input logic wr, input write_width_t w, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, input int hold,
                     output logic [31:0] exp_rd);
    int n, o, L;
    bit split;
    logic [31:0] wi, wi1, ld, d1, d2, ba;
    logic [3:0]  be1, be2;
    int ln;
    n  = (w == W_BYTE) ? 1 : (w == W_HALF) ? 2 : 4;
    o  = int'(a[1:0]);
    wi = a >> 2;
    wi1 = wi + 1;
    split = (o + n > 4);
    be1 = 0; be2 = 0; d1 = 0; d2 = 0; ld = 0;
    for (int i = 0; i < n; i++) begin
      ba = a + i;
      ln = int'(ba[1:0]);
      if ((ba >> 2) != wi) begin be2[ln] = 1'b1; d2[8*ln +: 8] = wd[8*i +: 8]; end
      else                 begin be1[ln] = 1'b1; d1[8*ln +: 8] = wd[8*i +: 8]; end
      ld[8*i +: 8] = mem[ba[11:2]][8*ln +: 8];
    end
    if (!uns && n < 4 && ld[8*n-1])
      for (int i = n; i < 4; i++) ld[8*i +: 8] = 8'hFF;
    exp_rd = wr ? 32'h0 : ld;
    L = 2 + int'(split) + int'(!wr);

    req_write = wr; req_width = w; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= L; k++) begin
      e_k = k; e_ready = 0;
      e_en = (k == 1) || (k == 2 && split);
      e_we = wr;
      e_addr = (k == 1) ? wi[9:0] : wi1[9:0];
      e_be = !e_en ? 4'h0 : (k == 1) ? be1 : be2;
      e_wdata = (!e_en || !wr) ? 32'h0 : (k == 1) ? d1 : d2;
      e_rvalid = (k == L);
      e_rdata = exp_rd;
      if (k < L) begin @(posedge clk); #1; end
    end
    for (int h = 0; h < hold; h++) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    idle_exp(1'b1);
  endtask

  logic [31:0] r;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h000] = 32'h11223344;
    mem[10'h3FF] = 32'hAABBCCDD;
    mem[10'h040] = 32'h80FFFFFF;
    mem[10'h041] = 32'h55AA6677;
    mem[10'h043] = 32'h9ABC0000;
    sram_rdata = 0;
    req_valid = 0; req_write = 0; req_width = W_BYTE; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; resp_ready = 0;
    idle_exp(1'b1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_sram_be", sram_be, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", req_ready, 1);
    chk_on = 1;

    run(0, W_BYTE, 0, 32'h103, 32'h0, 0, r);
    chk("lb_model", r, 32'hFFFFFF80);
    chk("lb_dut", c_rd, 32'hFFFFFF80);
    run(0, W_BYTE, 1, 32'h103, 32'h0, 0, r);
    chk("lbu_dut", c_rd, 32'h00000080);

    run(1, W_WORD, 0, 32'h100, 32'hDEADBEEF, 0, r);
    chk("sw_addr", c1_addr, 10'h040);
    chk("sw_be", c1_be, 4'b1111);
    chk("sw_data", c1_wd, 32'hDEADBEEF);
    run(0, W_WORD, 0, 32'h100, 32'h0, 0, r);
    chk("lw_back", c_rd, 32'hDEADBEEF);

    run(1, W_HALF, 0, 32'h107, 32'h1234, 0, r);
    chk("sh_b1_addr", c1_addr, 10'h041);
    chk("sh_b1_be", c1_be, 4'b1000);
    chk("sh_b1_lane3", c1_wd[31:24], 8'h34);
    chk("sh_b2_addr", c2_addr, 10'h042);
    chk("sh_b2_be", c2_be, 4'b0001);
    chk("sh_b2_lane0", c2_wd[7:0], 8'h12);

    run(0, W_WORD, 0, 32'hFFF, 32'h0, 0, r);
    chk("lw_wrap_addr", c2_addr, 10'h000);
    chk("lw_wrap_data", c_rd, 32'h223344AA);

    run(0, W_HALF, 0, 32'h106, 32'h0, 5, r);
    chk("lh_hold", c_rd, 32'h000034AA);
    run(0, W_HALF, 0, 32'h10E, 32'h0, 0, r);
    chk("lh_neg", c_rd, 32'hFFFF9ABC);

    run(1, W_WORD, 0, 32'h20A, 32'hCAFEF00D, 1, r);
    chk("sw_split_b1", {c1_be, c1_wd}, {4'b1100, 32'hF00D0000});
    chk("sw_split_b2", {c2_be, c2_wd}, {4'b0011, 32'h0000CAFE});
    run(0, W_HALF, 1, 32'h20B, 32'h0, 0, r);
    chk("lhu_split", c_rd, 32'h0000FEF0);

    run(1, W_BYTE, 0, 32'h301, 32'h000000A5, 0, r);
    chk("sb_lane1", {c1_be, c1_wd}, {4'b0010, 32'h0000A500});

    // Reset lands during beat 1 of a split store; beat 2 must never appear.
    req_write = 1; req_width = W_HALF; req_unsigned = 0;
    req_addr = 32'h107; req_wdata = 32'h5678; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    chk_on = 0;
    chk("rst_mid_beat1", sram_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {req_ready, resp_valid, sram_en, sram_we, sram_be, sram_addr},
        {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'h0});
    chk("rst_mid_data", {resp_rdata, sram_wdata}, 64'h0);
    repeat (2) begin @(posedge clk); #1; chk("rst_mid_no_beat", sram_en, 0); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_no_beat2", sram_en, 0);
    chk("rst_mid_mem42", mem[10'h042][7:0], 8'h12);
    chk("rst_mid_mem41", mem[10'h041][31:24], 8'h34);
    idle_exp(1'b1);
    chk_on = 1;
    run(0, W_BYTE, 1, 32'h108, 32'h0, 0, r);
    chk("lbu_after_rst", c_rd, 32'h00000012);

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS_LOG2, default 10, giving the SRAM word-address width.
REQ-002 SHALL have parameter XLEN, default isa_types::XLEN (32), giving the data width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when valid&ready
- req_write  in  1  1=store, 0=load
- req_width  in  write_width_t  byte/halfword/word
- req_unsigned  in  1  zero-extend load (LBU/LHU)
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, low-aligned
- resp_valid  out  1  response held until taken
- resp_ready  in  1  response consumed when valid&ready
- resp_rdata  out  XLEN  extended load data, 0 for stores
- sram_en  out  1  SRAM access this cycle
- sram_we  out  1  write strobe
- sram_addr  out  MEM_WORDS_LOG2  word address
- sram_be  out  4  byte-lane enables
- sram_wdata  out  XLEN  lane-positioned write data
- sram_rdata  in  XLEN  read data, valid the cycle after a read beat

Function
REQ-005 SHALL have FSM states IDLE, BEAT1, BEAT2, CAPTURE, RESP.
REQ-006 SHALL assert req_ready only in IDLE, and SHALL register addr, width, write, unsigned and wdata on accept.
REQ-007 SHALL define offset o=addr[1:0], n=1/2/4 bytes, word W=addr[XLEN-1:2]; access is split iff o+n>4.
REQ-008 SHALL transition BEAT1->BEAT2 if split, else ->CAPTURE on a load, else ->RESP.
REQ-009 SHALL transition BEAT2->CAPTURE on a load, else ->RESP; CAPTURE->RESP; RESP->IDLE on resp_ready.
REQ-010 SHALL assert sram_en only in BEAT1 (addr W) and BEAT2 (addr W+1 mod 2^30, truncated to MEM_WORDS_LOG2), with sram_we=req_write.
REQ-011 SHALL drive all sram_* outputs and resp_* outputs from registers only.
REQ-012 SHALL, for stores, compute be8=((1<<n)-1)<<o and d64=zero-extended wdata<<8*o; BEAT1 drives be8[3:0]/d64[31:0] and BEAT2 drives be8[7:4]/d64[63:32].
REQ-013 SHALL, for loads, capture beat-1 data in the cycle after BEAT1 and the last-beat data in CAPTURE, form {beat2,beat1}>>8*o, keep n bytes, then sign- or zero-extend per req_unsigned (ignored for words).
REQ-014 SHALL have latency from the accept edge to resp_valid of: store 2 cycles, load 3, split store 3, split load 4.
REQ-015 SHALL hold resp_valid and resp_rdata stable until resp_ready, which may already be high on the first RESP cycle.
REQ-016 SHALL NOT accept a new request in the same cycle as a response handshake; the next accept occurs in the following IDLE cycle.
REQ-017 SHALL drive sram_be=0 and sram_wdata=0 whenever sram_en=0.

Reset
REQ-018 SHALL, while rst_n=0, asynchronously force state=IDLE, req_ready=0, resp_valid=0, resp_rdata=0, sram_en=0, sram_we=0, sram_addr=0, sram_be=0 and sram_wdata=0.
REQ-019 SHALL assert req_ready in the first cycle after rst_n rises.
REQ-020 SHALL discard any in-flight access when reset is asserted mid-operation, with no further SRAM beat issued.

Structure
REQ-021 SHALL reuse isa_types::write_width_t and XLEN from the shared package, and the package SHALL gain a width_bytes(write_width_t) function returning 1/2/4.
REQ-022 SHALL keep the FSM state enum local to the module.
REQ-023 SHALL contain the lane shift/extend logic in one combinational sub-module, mem_lane_align.

Verification
REQ-024 SHALL verify an aligned word store with addr=0x100 and wdata=0xDEADBEEF -> one beat with sram_addr=0x40, be=1111, data 0xDEADBEEF, and resp_valid at +2.
REQ-025 SHALL verify a byte load with addr=0x103, unsigned=0 and SRAM word 0x80FFFFFF -> resp_rdata=0xFFFFFF80 at +3; with unsigned=1 -> 0x00000080.
REQ-026 SHALL verify a split halfword store with addr=0x107 and wdata=0x1234 -> beat1 addr 0x41, be=1000, lane3=0x34; beat2 addr 0x42, be=0001, lane0=0x12; resp at +3.
REQ-027 SHALL verify a split word load at the top word (addr=0xFFF, MEM_WORDS_LOG2=10) -> beat2 sram_addr wraps to 0x000 and the data is assembled from both words at +4.
REQ-028 SHALL verify resp_ready held low for 5 cycles -> resp_valid/rdata stable, req_ready=0 throughout, and the next request accepted the cycle after the handshake.
REQ-029 SHALL verify rst_n pulsed low during BEAT1 of a split store -> no BEAT2 beat, all outputs 0, and req_ready=1 one cycle after release.
